// File: rtl/prom_loader.sv
// Program-memory loader for cpu15: reassembles a byte stream into 15-bit words,
// writes them to program memory, verifies a trailing XOR checksum, and stalls the CPU until the load succeeds.
module prom_loader #(
   parameter int unsigned WORDS = 16
) (
   input  logic        CLK_LD,
   input  logic        RESET_N,
   input  logic        START,
   input  logic [7:0]  BYTE_IN,
   input  logic        BYTE_VALID,
   output logic        BYTE_READY,
   output logic        WR_EN,
   output logic [7:0]  WR_ADDR,
   output logic [14:0] WR_DATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic        CPU_HOLD
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 15;
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   addr_q;
   logic [7:0]      xor_q;
   logic [6:0]      hi_q;
   logic            ready_q;
   logic            wr_en_q;
   logic [DW-1:0]   wr_data_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            hold_q;

   // ready_q is high exactly in HI/LO/CSUM, so this is the handshake
   logic accept;
   assign accept = BYTE_VALID && ready_q;

   // State machine; every output register is updated alongside its state transition
   always_ff @(posedge CLK_LD or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         xor_q     <= '0;
         hi_q      <= '0;
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= 1'b1;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (START) begin
                  state_q <= S_HI;
                  addr_q  <= '0;
                  xor_q   <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  hold_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            S_HI: begin
               if (accept) begin
                  if (BYTE_IN[7]) begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_LO;
                     hi_q    <= BYTE_IN[6:0];
                     xor_q   <= xor_q ^ BYTE_IN;
                  end
               end
            end
            S_LO: begin
               if (accept) begin
                  state_q   <= S_WRITE;
                  wr_data_q <= {hi_q, BYTE_IN};
                  xor_q     <= xor_q ^ BYTE_IN;
                  wr_en_q   <= 1'b1;
                  ready_q   <= 1'b0;
               end
            end
            S_WRITE: begin
               ready_q <= 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_q <= S_CSUM;
               end else begin
                  state_q <= S_HI;
                  addr_q  <= addr_q + AW'(1);
               end
            end
            S_CSUM: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
                  if (BYTE_IN == xor_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               hold_q  <= 1'b1;
            end
         endcase
      end
   end

   assign BYTE_READY = ready_q;
   assign WR_EN      = wr_en_q;
   assign WR_ADDR    = addr_q;
   assign WR_DATA    = wr_data_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign CPU_HOLD   = hold_q;

endmodule
